// File: rtl/bus_responder_if.sv
// CPU-side and external-side bus signals of bus_responder, bundled with
// a responder (slave) view and a requester/bench (master) view.
interface bus_responder_if;
  logic [15:0] addr;
  logic        read;
  logic        write;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        stall;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;

  modport slave (
    input  addr, read, write, wdata, ext_rdata, ext_ack,
    output rdata, stall, ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output addr, read, write, wdata, ext_rdata, ext_ack,
    input  rdata, stall, ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/bus_responder.sv
// CPU bus responder: 2 KiB internal RAM (mirrored below 16'h2000) with optional
// wait states, everything else forwarded to an external bus. Define
// BUS_RESP_WP_EN to drop writes at/above ROM_BASE and count them in wp_count.
module bus_responder #(
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] ROM_BASE    = 16'h8000
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_responder_if.slave    bus
`ifdef BUS_RESP_WP_EN
  ,
  output logic [7:0]        wp_count
`endif
);

`ifdef BUS_RESP_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, EXT} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [10:0] idx_l;
  logic        we_l;
  logic [7:0]  wdata_l;

  logic [7:0]  mem [0:2047];

  logic        op_rd, op_wr, is_int, wp_hit;
  logic        stall_c, ram_we, rd_ram, rd_ext, lat_en, ext_start, ext_done;
  logic [10:0] acc_idx;
  logic [7:0]  acc_wd;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Read wins when both strobes are high.
  assign op_rd  = bus.read;
  assign op_wr  = bus.write & ~bus.read;
  assign is_int = (bus.addr < 16'h2000);
  assign wp_hit = WP_EN && (state == IDLE) && !is_int && op_wr && (bus.addr >= ROM_BASE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall_c   = 1'b0;
    ram_we    = 1'b0;
    rd_ram    = 1'b0;
    rd_ext    = 1'b0;
    lat_en    = 1'b0;
    ext_start = 1'b0;
    ext_done  = 1'b0;
    acc_idx   = bus.addr[10:0];
    acc_wd    = bus.wdata;
    unique case (state)
      IDLE: begin
        if (op_rd || op_wr) begin
          if (is_int) begin
            if (WAIT_CYCLES == 0) begin
              ram_we = op_wr;
              rd_ram = op_rd;
            end else begin
              stall_c = 1'b1;
              cnt_n   = 4'(WAIT_CYCLES);
              lat_en  = 1'b1;
              state_n = WAIT;
            end
          end else if (!wp_hit) begin
            stall_c   = 1'b1;
            lat_en    = 1'b1;
            ext_start = 1'b1;
            state_n   = EXT;
          end
        end
      end
      WAIT: begin
        acc_idx = idx_l;
        acc_wd  = wdata_l;
        cnt_n   = cnt - 4'd1;
        if (cnt == 4'd1) begin
          ram_we  = we_l;
          rd_ram  = ~we_l;
          state_n = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      EXT: begin
        if (bus.ext_ack) begin
          rd_ext   = ~we_l;
          ext_done = 1'b1;
          state_n  = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset must drop the hold even while a request is presented.
  assign bus.stall = rst_n & stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      idx_l         <= 11'd0;
      we_l          <= 1'b0;
      wdata_l       <= 8'h00;
      bus.rdata     <= 8'h00;
      bus.ext_req   <= 1'b0;
      bus.ext_we    <= 1'b0;
      bus.ext_addr  <= 16'h0000;
      bus.ext_wdata <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (lat_en) begin
        idx_l   <= bus.addr[10:0];
        we_l    <= op_wr;
        wdata_l <= bus.wdata;
      end
      if (rd_ram)
        bus.rdata <= mem[acc_idx];
      else if (rd_ext)
        bus.rdata <= bus.ext_rdata;
      if (ext_start) begin
        bus.ext_req   <= 1'b1;
        bus.ext_we    <= op_wr;
        bus.ext_addr  <= bus.addr;
        bus.ext_wdata <= bus.wdata;
      end else if (ext_done) begin
        bus.ext_req <= 1'b0;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[acc_idx] <= acc_wd;
  end

`ifdef BUS_RESP_WP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wp_count <= 8'h00;
    else if (wp_hit)
      wp_count <= sat_inc8(wp_count);
  end
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one instance with no wait states (RAM,
// external, reset, write-protect) and one with three wait states.
module tb_bus_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_responder_if b0 ();
  bus_responder_if b3 ();
`ifdef BUS_RESP_WP_EN
  logic [7:0] wp_count0, wp_count3;
`endif

  bus_responder #(.WAIT_CYCLES(0), .ROM_BASE(16'h8000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
`ifdef BUS_RESP_WP_EN
    , .wp_count(wp_count0)
`endif
  );

  bus_responder #(.WAIT_CYCLES(3), .ROM_BASE(16'h8000)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
`ifdef BUS_RESP_WP_EN
    , .wp_count(wp_count3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single zero-wait access on dut0, completing at the next rising edge.
  task automatic acc0(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    b0.addr = a; b0.read = rd; b0.write = wr; b0.wdata = d;
    #1 check("acc0_stall", b0.stall, 1'b0);
    @(posedge clk);
    #1 b0.read = 1'b0; b0.write = 1'b0;
  endtask

  // Access on dut3; returns how many low-phase samples showed stall=1.
  task automatic acc3(input logic rd, input logic [15:0] a, input logic [7:0] d, output int stalls);
    @(negedge clk);
    b3.addr = a; b3.read = rd; b3.write = ~rd; b3.wdata = d;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!b3.stall) break;
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 b3.read = 1'b0; b3.write = 1'b0;
  endtask

  initial begin
    int req_cnt, stall_cnt, st3;
    bit saw_stall, saw_req;

    b0.addr = 16'h4000; b0.read = 1'b1; b0.write = 1'b0; b0.wdata = 8'h00;
    b0.ext_rdata = 8'h00; b0.ext_ack = 1'b0;
    b3.addr = 16'h0000; b3.read = 1'b0; b3.write = 1'b0; b3.wdata = 8'h00;
    b3.ext_rdata = 8'h00; b3.ext_ack = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_stall", b0.stall, 1'b0);
    check("rst_ext_req", b0.ext_req, 1'b0);
    check("rst_rdata", b0.rdata, 8'h00);
    check("rst_ext_addr", b0.ext_addr, 16'h0000);
`ifdef BUS_RESP_WP_EN
    check("rst_wp_count", wp_count0, 8'h00);
`endif
    b0.read = 1'b0;
    rst_n = 1'b1;

    // Mirror: write 0012, read back through 1812.
    acc0(1'b0, 1'b1, 16'h0012, 8'hA5);
    @(negedge clk) check("wr_keeps_rdata", b0.rdata, 8'h00);
    acc0(1'b1, 1'b0, 16'h1812, 8'h00);
    @(negedge clk) check("mirror_rd", b0.rdata, 8'hA5);
    acc0(1'b0, 1'b1, 16'h07FF, 8'h5A);
    acc0(1'b1, 1'b0, 16'h0FFF, 8'h00);
    @(negedge clk) check("mirror_top", b0.rdata, 8'h5A);
    @(negedge clk) check("idle_holds", b0.rdata, 8'h5A);

    // Read and write together act as a read.
    acc0(1'b0, 1'b1, 16'h0005, 8'h11);
    acc0(1'b1, 1'b1, 16'h0005, 8'h77);
    @(negedge clk) check("rw_is_read", b0.rdata, 8'h11);
    acc0(1'b1, 1'b0, 16'h0012, 8'h00);
    acc0(1'b1, 1'b0, 16'h0005, 8'h00);
    @(negedge clk) check("rw_ram_kept", b0.rdata, 8'h11);

    // External read, ack in the fourth EXT cycle.
    @(negedge clk);
    b0.addr = 16'h4020; b0.read = 1'b1;
    #1 check("ext_idle_stall", b0.stall, 1'b1);
    stall_cnt = 1; req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (b0.ext_req) req_cnt++;
      if (req_cnt == 4) begin b0.ext_ack = 1'b1; b0.ext_rdata = 8'h3C; end
      #1;
      if (i == 0) begin
        check("ext_addr", b0.ext_addr, 16'h4020);
        check("ext_we_rd", b0.ext_we, 1'b0);
      end
      if (b0.stall) stall_cnt++;
      else break;
    end
    check("ext_req_cycles", req_cnt, 4);
    check("ext_stall_cycles", stall_cnt, 4);
    @(posedge clk);
    #1 b0.ext_ack = 1'b0; b0.read = 1'b0;
    @(negedge clk);
    check("ext_req_drop", b0.ext_req, 1'b0);
    check("ext_rdata", b0.rdata, 8'h3C);

    // External write.
    @(negedge clk);
    b0.addr = 16'h6000; b0.write = 1'b1; b0.wdata = 8'h9E;
    @(negedge clk);
    check("extw_req", b0.ext_req, 1'b1);
    check("extw_we", b0.ext_we, 1'b1);
    check("extw_wdata", b0.ext_wdata, 8'h9E);
    b0.ext_ack = 1'b1;
    #1 check("extw_ack_stall", b0.stall, 1'b0);
    @(posedge clk);
    #1 b0.ext_ack = 1'b0; b0.write = 1'b0;
    @(negedge clk);
    check("extw_rdata_kept", b0.rdata, 8'h3C);

`ifdef BUS_RESP_WP_EN
    saw_stall = 1'b0; saw_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      b0.addr = 16'hC000; b0.write = 1'b1; b0.wdata = 8'(i);
      #1;
      if (b0.stall) saw_stall = 1'b1;
      if (b0.ext_req) saw_req = 1'b1;
    end
    @(negedge clk);
    b0.write = 1'b0;
    if (b0.ext_req) saw_req = 1'b1;
    check("wp_no_stall", saw_stall, 1'b0);
    check("wp_no_req", saw_req, 1'b0);
    check("wp_count_sat", wp_count0, 8'hFF);
    @(negedge clk);
    b0.addr = 16'h6000; b0.write = 1'b1; b0.wdata = 8'h42;
    #1 check("wp_low_stall", b0.stall, 1'b1);
    @(negedge clk);
    check("wp_low_req", b0.ext_req, 1'b1);
    b0.ext_ack = 1'b1;
    @(posedge clk);
    #1 b0.ext_ack = 1'b0; b0.write = 1'b0;
`else
    saw_stall = 1'b0; saw_req = 1'b0;
`endif

    // Reset during EXT, then a late ack.
    @(negedge clk);
    b0.addr = 16'h5000; b0.read = 1'b1;
    @(negedge clk);
    check("rstx_in_ext", b0.ext_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstx_req", b0.ext_req, 1'b0);
    check("rstx_stall", b0.stall, 1'b0);
    check("rstx_rdata", b0.rdata, 8'h00);
`ifdef BUS_RESP_WP_EN
    check("rstx_wp_count", wp_count0, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1; b0.read = 1'b0; b0.ext_ack = 1'b1; b0.ext_rdata = 8'hEE;
    @(negedge clk);
    check("late_ack_req", b0.ext_req, 1'b0);
    check("late_ack_stall", b0.stall, 1'b0);
    check("late_ack_rdata", b0.rdata, 8'h00);
    b0.ext_ack = 1'b0;

    // Three wait states on the internal RAM.
    acc3(1'b0, 16'h0100, 8'hC3, st3);
    check("w3_wr_stalls", st3, 3);
    @(negedge clk) check("w3_wr_rdata", b3.rdata, 8'h00);
    acc3(1'b1, 16'h0100, 8'h00, st3);
    check("w3_rd_stalls", st3, 3);
    @(negedge clk) check("w3_rd_rdata", b3.rdata, 8'hC3);
    acc3(1'b1, 16'h1900, 8'h00, st3);
    check("w3_mirror_stalls", st3, 3);
    @(negedge clk) check("w3_mirror_rdata", b3.rdata, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
